// File: rtl/ctrl_delay_pipe_if.sv
// Control-word bus around the MAC control delay pipe: sequencer word in, delayed word out, stall/flush, occupancy.
// master = sequencer/MAC-array side, slave = the delay pipe itself.
interface ctrl_delay_pipe_if #(
    parameter int DEPTH = 1,
    parameter int SHW   = 5,
    parameter int IDXW  = 2,
    parameter int ODW   = 4
);
    localparam int CNTW = $clog2(DEPTH + 1);

    // sequencer side
    logic            VALID0;
    logic            START_CALC0;
    logic            ILoad0;
    logic            WLoad0;
    logic [SHW-1:0]  shamt0;
    logic [IDXW-1:0] ICOL0;
    logic [IDXW-1:0] WROW0;
    logic [ODW-1:0]  ODST0;
    logic            STALL;
    logic            FLUSH;
    logic            IN_RDY;

    // MAC-array side
    logic            VALID1;
    logic            START_CALC1;
    logic            ILoad1;
    logic            WLoad1;
    logic [SHW-1:0]  shamt1;
    logic [IDXW-1:0] ICOL1;
    logic [IDXW-1:0] WROW1;
    logic [ODW-1:0]  ODST1;
    logic [CNTW-1:0] OCC;
    logic            EMPTY;

    modport master (
        output VALID0, START_CALC0, ILoad0, WLoad0, shamt0, ICOL0, WROW0, ODST0,
        output STALL, FLUSH,
        input  IN_RDY,
        input  VALID1, START_CALC1, ILoad1, WLoad1, shamt1, ICOL1, WROW1, ODST1,
        input  OCC, EMPTY
    );

    modport slave (
        input  VALID0, START_CALC0, ILoad0, WLoad0, shamt0, ICOL0, WROW0, ODST0,
        input  STALL, FLUSH,
        output IN_RDY,
        output VALID1, START_CALC1, ILoad1, WLoad1, shamt1, ICOL1, WROW1, ODST1,
        output OCC, EMPTY
    );
endinterface

// File: rtl/ctrl_delay_pipe.sv
// DEPTH-stage delay line for the MAC control word with per-stage valid, flush and occupancy; latency DEPTH cycles plus stall cycles.
// Backpressure only through STALL (freezes every stage, IN_RDY=~STALL); there is no full condition.
module ctrl_delay_pipe #(
    parameter int DEPTH = 1,
    parameter int SHW   = 5,
    parameter int IDXW  = 2,
    parameter int ODW   = 4
) (
    input  logic            CLK,
    input  logic            RST,
    ctrl_delay_pipe_if.slave bus
);
    localparam int CNTW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic            start_calc;
        logic            iload;
        logic            wload;
        logic [SHW-1:0]  shamt;
        logic [IDXW-1:0] icol;
        logic [IDXW-1:0] wrow;
        logic [ODW-1:0]  odst;
    } ctrl_t;

    ctrl_t           in_word;
    ctrl_t           out_word;
    ctrl_t           stage_pay [DEPTH];
    logic [DEPTH-1:0] stage_vld;
    logic [CNTW-1:0] occ_q;
    logic            accept;
    logic            retire;
    logic            out_vld;

    // Invalid stages always carry an all-zero payload, so bubbles never leak stale fields.
    always_comb begin
        in_word = '0;
        if (bus.VALID0) begin
            in_word.start_calc = bus.START_CALC0;
            in_word.iload      = bus.ILoad0;
            in_word.wload      = bus.WLoad0;
            in_word.shamt      = bus.shamt0;
            in_word.icol       = bus.ICOL0;
            in_word.wrow       = bus.WROW0;
            in_word.odst       = bus.ODST0;
        end
    end

    assign accept = bus.VALID0 & ~bus.STALL;
    assign retire = stage_vld[DEPTH-1] & ~bus.STALL;

    // Flush wins over stall so a frozen pipe can still be emptied.
    always_ff @(posedge CLK) begin
        if (RST || bus.FLUSH) begin
            stage_vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_pay[k] <= '0;
            end
            occ_q <= '0;
        end else if (!bus.STALL) begin
            stage_vld[0] <= bus.VALID0;
            stage_pay[0] <= in_word;
            for (int k = 1; k < DEPTH; k++) begin
                stage_vld[k] <= stage_vld[k-1];
                stage_pay[k] <= stage_pay[k-1];
            end
            occ_q <= occ_q + CNTW'(accept) - CNTW'(retire);
        end
    end

    assign out_word = stage_pay[DEPTH-1];
    // Masking valid with STALL makes a held word strobe downstream only once.
    assign out_vld  = stage_vld[DEPTH-1] & ~bus.STALL;

    assign bus.IN_RDY      = ~bus.STALL;
    assign bus.VALID1      = out_vld;
    assign bus.START_CALC1 = out_word.start_calc & out_vld;
    assign bus.ILoad1      = out_word.iload & out_vld;
    assign bus.WLoad1      = out_word.wload & out_vld;
    assign bus.shamt1      = out_word.shamt;
    assign bus.ICOL1       = out_word.icol;
    assign bus.WROW1       = out_word.wrow;
    assign bus.ODST1       = out_word.odst;
    assign bus.OCC         = occ_q;
    assign bus.EMPTY       = (occ_q == '0);
endmodule

// File: tb/tb_ctrl_delay_pipe.sv
// Bench for ctrl_delay_pipe: five depths share one directed stimulus stream; each has its own scoreboard queue.
module tb_ctrl_delay_pipe;
    localparam int NI = 5;

    typedef struct packed {
        logic       sc;
        logic       il;
        logic       wl;
        logic [4:0] sh;
        logic [1:0] ic;
        logic [1:0] wr;
        logic [3:0] od;
    } word_t;

    typedef struct {
        word_t w;
        int    tag;
    } exp_t;

    logic  CLK = 1'b0;
    logic  RST;
    logic  v0;
    word_t w0;
    logic  stall;
    logic  flush;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic word_t mk(input logic sc, input logic il, input logic wl, input logic [4:0] sh,
                                 input logic [1:0] ic, input logic [1:0] wr, input logic [3:0] od);
        word_t w;
        w.sc = sc; w.il = il; w.wl = wl; w.sh = sh; w.ic = ic; w.wr = wr; w.od = od;
        return w;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 4 : 8;

        ctrl_delay_pipe_if #(.DEPTH(D), .SHW(5), .IDXW(2), .ODW(4)) bus ();

        assign bus.VALID0      = v0;
        assign bus.START_CALC0 = w0.sc;
        assign bus.ILoad0      = w0.il;
        assign bus.WLoad0      = w0.wl;
        assign bus.shamt0      = w0.sh;
        assign bus.ICOL0       = w0.ic;
        assign bus.WROW0       = w0.wr;
        assign bus.ODST0       = w0.od;
        assign bus.STALL       = stall;
        assign bus.FLUSH       = flush;

        ctrl_delay_pipe #(.DEPTH(D), .SHW(5), .IDXW(2), .ODW(4)) u_dut (
            .CLK (CLK),
            .RST (RST),
            .bus (bus.slave)
        );

        exp_t q[$];
        int   shift_cnt = 0;
        bit   mon_en    = 1'b0;

        // Stimulus bookkeeping: every accepted word is queued, tagged with its shift-edge count.
        always @(posedge CLK) begin
            if (RST) begin
                q.delete();
                mon_en <= 1'b1;
            end else if (flush) begin
                q.delete();
            end else if (!stall) begin
                shift_cnt <= shift_cnt + 1;
                if (v0) q.push_back('{w: w0, tag: shift_cnt + 1});
            end
        end

        // Monitor: the head word is due once it has made D-1 further shifts after acceptance.
        always @(negedge CLK) begin : p_mon
            word_t ew;
            logic  due;
            logic  ev;
            if (mon_en) begin
                due = (q.size() > 0) && (shift_cnt - q[0].tag == D - 1);
                ev  = due && !stall;
                ew  = due ? q[0].w : word_t'(0);
                chk($sformatf("d%0d_occ", D), 32'(bus.OCC), 32'(q.size()));
                chk($sformatf("d%0d_empty", D), 32'(bus.EMPTY), 32'(q.size() == 0));
                chk($sformatf("d%0d_in_rdy", D), 32'(bus.IN_RDY), 32'(!stall));
                chk($sformatf("d%0d_valid1", D), 32'(bus.VALID1), 32'(ev));
                chk($sformatf("d%0d_strobes", D), 32'({bus.START_CALC1, bus.ILoad1, bus.WLoad1}),
                    32'({ew.sc, ew.il, ew.wl} & {3{ev}}));
                chk($sformatf("d%0d_fields", D), 32'({bus.shamt1, bus.ICOL1, bus.WROW1, bus.ODST1}),
                    32'({ew.sh, ew.ic, ew.wr, ew.od}));
                if (ev) void'(q.pop_front());
            end
        end
    end

    task automatic step(input logic v, input word_t w, input logic st, input logic fl);
        v0    = v;
        w0    = w;
        stall = st;
        flush = fl;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, word_t'(0), 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        word_t      junk;
        int         exp_occ [6];
        int         exp_vld [6];
        int         exp_od  [6];
        int         exp_sc  [6];

        exp_occ = '{1, 1, 2, 1, 1, 0};
        exp_vld = '{0, 0, 1, 0, 1, 0};
        exp_od  = '{0, 0, 1, 0, 5, 0};
        exp_sc  = '{0, 0, 0, 0, 1, 0};
        junk    = mk(1, 1, 1, 31, 3, 3, 15);

        // Reset held two cycles with an all-ones valid word presented.
        RST   = 1'b1;
        v0    = 1'b1;
        w0    = '1;
        stall = 1'b0;
        flush = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("rst_d3_valid1", 32'(g_dut[2].bus.VALID1), 0);
        chk("rst_d3_occ",    32'(g_dut[2].bus.OCC), 0);
        chk("rst_d3_empty",  32'(g_dut[2].bus.EMPTY), 1);
        chk("rst_d3_odst",   32'(g_dut[2].bus.ODST1), 0);
        chk("rst_d8_shamt",  32'(g_dut[4].bus.shamt1), 0);
        chk("rst_d8_iload",  32'(g_dut[4].bus.ILoad1), 0);
        chk("rst_d1_in_rdy", 32'(g_dut[0].bus.IN_RDY), 1);
        RST = 1'b0;

        // A, bubble with garbage fields, B, then idle; observed on the DEPTH=3 pipe.
        for (int e = 0; e < 6; e++) begin
            case (e)
                0:       step(1'b1, mk(0, 0, 0, 0, 0, 0, 1), 1'b0, 1'b0);
                1:       step(1'b0, junk, 1'b0, 1'b0);
                2:       step(1'b1, mk(1, 0, 0, 0, 0, 0, 5), 1'b0, 1'b0);
                default: step(1'b0, word_t'(0), 1'b0, 1'b0);
            endcase
            chk($sformatf("seq_occ_e%0d", e + 1),  32'(g_dut[2].bus.OCC), 32'(exp_occ[e]));
            chk($sformatf("seq_vld_e%0d", e + 1),  32'(g_dut[2].bus.VALID1), 32'(exp_vld[e]));
            chk($sformatf("seq_odst_e%0d", e + 1), 32'(g_dut[2].bus.ODST1), 32'(exp_od[e]));
            chk($sformatf("seq_sc_e%0d", e + 1),   32'(g_dut[2].bus.START_CALC1), 32'(exp_sc[e]));
        end
        idle(10);

        // Stall mid-stream: W0 sits in the last stage of DEPTH=2 while frozen.
        step(1'b1, mk(0, 1, 0, 3, 1, 2, 2), 1'b0, 1'b0);
        step(1'b1, mk(1, 0, 1, 4, 2, 1, 3), 1'b0, 1'b0);
        chk("stl_pre_vld",  32'(g_dut[1].bus.VALID1), 1);
        chk("stl_pre_odst", 32'(g_dut[1].bus.ODST1), 2);
        for (int s = 0; s < 3; s++) begin
            step(1'b1, junk, 1'b1, 1'b0);
            chk($sformatf("stl_vld_%0d", s),  32'(g_dut[1].bus.VALID1), 0);
            chk($sformatf("stl_il_%0d", s),   32'(g_dut[1].bus.ILoad1), 0);
            chk($sformatf("stl_occ_%0d", s),  32'(g_dut[1].bus.OCC), 2);
            chk($sformatf("stl_odst_%0d", s), 32'(g_dut[1].bus.ODST1), 2);
        end
        step(1'b1, mk(0, 0, 1, 6, 3, 0, 4), 1'b0, 1'b0);
        step(1'b1, mk(1, 1, 0, 7, 0, 3, 6), 1'b0, 1'b0);
        idle(12);

        // Flush with a stalled valid word presented; DEPTH=4 holds three words.
        step(1'b1, mk(1, 0, 0, 8, 1, 1, 8), 1'b0, 1'b0);
        step(1'b1, mk(0, 1, 0, 9, 2, 2, 9), 1'b0, 1'b0);
        step(1'b1, mk(0, 0, 1, 10, 3, 3, 10), 1'b0, 1'b0);
        chk("fl_pre_occ", 32'(g_dut[3].bus.OCC), 3);
        step(1'b1, junk, 1'b1, 1'b1);
        chk("fl_occ",    32'(g_dut[3].bus.OCC), 0);
        chk("fl_vld",    32'(g_dut[3].bus.VALID1), 0);
        chk("fl_fields", 32'({g_dut[3].bus.shamt1, g_dut[3].bus.ICOL1, g_dut[3].bus.WROW1, g_dut[3].bus.ODST1}), 0);
        step(1'b1, mk(0, 1, 1, 9, 2, 3, 11), 1'b0, 1'b0);
        idle(2);
        chk("fl_next_early", 32'(g_dut[3].bus.VALID1), 0);
        idle(1);
        chk("fl_next_vld",  32'(g_dut[3].bus.VALID1), 1);
        chk("fl_next_odst", 32'(g_dut[3].bus.ODST1), 11);
        idle(12);

        // Continuous stream: DEPTH=8 saturates at 8, DEPTH=1 at 1.
        for (int i = 0; i < 20; i++) begin
            b = 8'(i);
            step(1'b1, mk(b[0], b[1], b[2], b[4:0], b[1:0], ~b[1:0], b[3:0]), 1'b0, 1'b0);
            chk($sformatf("full_occ8_%0d", i), 32'(g_dut[4].bus.OCC), 32'((i + 1 < 8) ? i + 1 : 8));
            if (i >= 7) begin
                chk($sformatf("full_odst8_%0d", i), 32'(g_dut[4].bus.ODST1), 32'((i - 7) % 16));
            end
        end
        chk("full_occ1", 32'(g_dut[0].bus.OCC), 1);
        idle(12);

        // Reset mid-stream on DEPTH=3: in-flight words never appear.
        step(1'b1, mk(0, 1, 1, 1, 1, 1, 1), 1'b0, 1'b0);
        step(1'b1, mk(1, 1, 1, 2, 2, 2, 2), 1'b0, 1'b0);
        RST = 1'b1;
        step(1'b1, mk(0, 1, 1, 3, 3, 3, 3), 1'b0, 1'b0);
        RST = 1'b0;
        for (int r = 0; r < 5; r++) begin
            chk($sformatf("mrst_il_%0d", r), 32'(g_dut[2].bus.ILoad1), 0);
            chk($sformatf("mrst_wl_%0d", r), 32'(g_dut[2].bus.WLoad1), 0);
            idle(1);
        end
        step(1'b1, mk(0, 1, 0, 5, 1, 0, 7), 1'b0, 1'b0);
        idle(1);
        chk("mrst_new_early", 32'(g_dut[2].bus.ILoad1), 0);
        idle(1);
        chk("mrst_new_il",   32'(g_dut[2].bus.ILoad1), 1);
        chk("mrst_new_wl",   32'(g_dut[2].bus.WLoad1), 0);
        chk("mrst_new_odst", 32'(g_dut[2].bus.ODST1), 7);
        idle(15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
